// File: rtl/stump_sequencer.sv
// Control sequencer for the STUMP processor: FETCH / EXECUTE / MEMORY / HALT with combinational decode.
// Optional macro STUMP_WAITSTATE_EN makes FETCH and MEMORY wait on mem_ready; without it both take one cycle.
module stump_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic [3:0]            cc,
  input  logic                  halt_req,
  output logic [1:0]            state,
  output logic                  fetch,
  output logic                  execute,
  output logic                  memory,
  output logic [15:0]           ir,
  output logic                  ext_op,
  output logic                  reg_write,
  output logic                  opB_mux_sel,
  output logic                  cc_en,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [2:0]            dest,
  output logic [2:0]            srcA,
  output logic [2:0]            srcB,
  output logic [2:0]            alu_func,
  output logic [1:0]            shift_op,
  output logic                  branch_taken,
  output logic [CNT_WIDTH-1:0]  retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_MEM   = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           ir_q, ir_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic                  ready;
  logic                  done;
  logic                  cond_true;
  logic                  is_ldst, is_bcc;
  logic                  flag_n, flag_z, flag_v, flag_c;

`ifdef STUMP_WAITSTATE_EN
  assign ready = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready = 1'b1;
`endif

  // Only bits [15:0] carry the instruction; wider buses are tolerated.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  assign {flag_n, flag_z, flag_v, flag_c} = cc;
  assign is_ldst = (ir_q[15:13] == 3'b110);
  assign is_bcc  = (ir_q[15:13] == 3'b111);

  always_comb begin
    cond_true = 1'b0;
    case (ir_q[11:8])
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = 1'b0;
      4'd2:  cond_true = ~(flag_c | flag_z);
      4'd3:  cond_true = flag_c | flag_z;
      4'd4:  cond_true = ~flag_c;
      4'd5:  cond_true = flag_c;
      4'd6:  cond_true = ~flag_z;
      4'd7:  cond_true = flag_z;
      4'd8:  cond_true = ~flag_v;
      4'd9:  cond_true = flag_v;
      4'd10: cond_true = ~flag_n;
      4'd11: cond_true = flag_n;
      4'd12: cond_true = flag_n ~^ flag_v;
      4'd13: cond_true = flag_n ^ flag_v;
      4'd14: cond_true = ~((flag_n ^ flag_v) | flag_z);
      default: cond_true = (flag_n ^ flag_v) | flag_z;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= 16'h0000;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // done marks instruction completion; halt_req is only looked at there or in HALT.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    done      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (ready) begin
          ir_d    = mem_rdata[15:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_ldst) state_d = S_MEM;
        else         done    = 1'b1;
      end
      S_MEM: begin
        if (ready) done = 1'b1;
      end
      default: begin
        if (!halt_req) state_d = S_FETCH;
      end
    endcase
    if (done) begin
      retired_d = retired_q + CNT_WIDTH'(1);
      state_d   = halt_req ? S_HALT : S_FETCH;
    end
  end

  always_comb begin
    ext_op       = 1'b0;
    reg_write    = 1'b0;
    opB_mux_sel  = 1'b0;
    cc_en        = 1'b0;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    dest         = 3'd0;
    srcA         = 3'd0;
    srcB         = 3'd0;
    alu_func     = 3'd0;
    shift_op     = 2'd0;
    branch_taken = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_ren   = 1'b1;
        reg_write = ready;
        dest      = 3'd7;
        srcA      = 3'd7;
      end
      S_EXEC: begin
        if (is_bcc) begin
          branch_taken = cond_true;
          ext_op       = 1'b1;
          dest         = 3'd7;
          srcA         = 3'd7;
          alu_func     = 3'b111;
          reg_write    = cond_true;
        end else if (is_ldst) begin
          alu_func    = 3'b110;
          opB_mux_sel = ir_q[12];
          srcA        = ir_q[7:5];
          srcB        = ir_q[4:2];
        end else begin
          reg_write = 1'b1;
          dest      = ir_q[10:8];
          srcA      = ir_q[7:5];
          alu_func  = ir_q[15:13];
          cc_en     = ir_q[11];
          if (ir_q[12]) begin
            opB_mux_sel = 1'b1;
          end else begin
            srcB     = ir_q[4:2];
            shift_op = ir_q[1:0];
          end
        end
      end
      S_MEM: begin
        mem_ren   = ~ir_q[11];
        mem_wen   = ir_q[11];
        reg_write = ~ir_q[11] & ready;
        dest      = ir_q[10:8];
        if (ir_q[11]) srcA = ir_q[10:8];
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign fetch   = (state_q == S_FETCH);
  assign execute = (state_q == S_EXEC);
  assign memory  = (state_q == S_MEM);
  assign ir      = ir_q;
  assign retired = retired_q;

endmodule

// File: doc/stump_sequencer.md
STUMP_SEQUENCER -- requirements
Module: stump_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning memory read-data width (minimum 16; IR taken from bits [15:0]).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning retired-instruction counter width.
REQ-003 SHALL have ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- mem_rdata  input  DATA_WIDTH  memory read data
- mem_ready  input  1  memory access complete
- cc  input  4  condition flags {N,Z,V,C}
- halt_req  input  1  request halt at instruction boundary
- state  output  2  FETCH=00, EXECUTE=01, MEMORY=10, HALT=11
- fetch, execute, memory  output  1 each  one-hot state flags; all 0 in HALT
- ir  output  16  registered instruction
- ext_op, reg_write, opB_mux_sel, cc_en, mem_ren, mem_wen  output  1 each  decoded controls
- dest, srcA, srcB, alu_func  output  3 each  decoded fields
- shift_op  output  2  shifter select
- branch_taken  output  1  Bcc condition true for current ir
- retired  output  CNT_WIDTH  completed-instruction count

Function
REQ-004 SHALL register state and ir; all decode outputs SHALL be combinational from state, ir and cc, with every unused field driven 0 (never X).
REQ-005 FETCH: mem_ren=1, reg_write=mem_ready, dest=srcA=7, alu_func=000, shift_op=00; on mem_ready, ir <= mem_rdata[15:0] and state -> EXECUTE; else stay.
REQ-006 EXECUTE, opcodes 000-101 (ADD,ADC,SUB,SBC,AND,OR): reg_write=1, dest=ir[10:8], srcA=ir[7:5], alu_func=ir[15:13], cc_en=ir[11]; ir[12]=0: srcB=ir[4:2], shift_op=ir[1:0], opB_mux_sel=0; ir[12]=1: opB_mux_sel=1, ext_op=0.
REQ-007 EXECUTE, opcode 110 (LDST): reg_write=0, alu_func=110, ext_op=0, opB_mux_sel=ir[12], srcA=ir[7:5], srcB=ir[4:2], next state MEMORY.
REQ-008 EXECUTE, opcode 111 (Bcc): ext_op=1, dest=srcA=7, alu_func=111, cc_en=0, reg_write=branch_taken.
REQ-009 branch_taken SHALL evaluate ir[11:8] against cc: 0 always, 1 never, 2 ~(C|Z), 3 C|Z, 4 ~C, 5 C, 6 ~Z, 7 Z, 8 ~V, 9 V, 10 ~N, 11 N, 12 N~^V, 13 N^V, 14 ~((N^V)|Z), 15 (N^V)|Z.
REQ-010 EXECUTE of non-LDST SHALL last exactly one cycle, then -> HALT if halt_req else FETCH.
REQ-011 MEMORY: mem_ren=~ir[11], mem_wen=ir[11], reg_write=~ir[11]&mem_ready, dest=ir[10:8], srcA=ir[10:8] when ir[11]=1; stay until mem_ready, then -> HALT if halt_req else FETCH.
REQ-012 retired SHALL increment by 1 on every EXECUTE->FETCH/HALT or MEMORY->FETCH/HALT transition, wrapping from all-ones to 0.
REQ-013 HALT: all enables 0; ir and retired held; -> FETCH the cycle after halt_req is sampled 0.
REQ-014 halt_req SHALL be ignored in FETCH and mid-MEMORY wait; it takes effect only at instruction completion.

Reset
REQ-015 rst sampled high SHALL set state=FETCH, ir=0, retired=0 on that edge, aborting any instruction or wait in progress; outputs then follow REQ-005.
REQ-016 rst SHALL take priority over mem_ready and halt_req.

Configuration
REQ-017 Macro STUMP_WAITSTATE_EN: defined -> mem_ready honoured as in REQ-005/011; undefined -> mem_ready ignored, treated as constant 1 (FETCH and MEMORY always one cycle).

Verification
REQ-018 Reset then mem_rdata=16'h0123 (ADD r1,r1,r0), mem_ready=1 -> states 00,01,00; in EXECUTE dest=1, srcA=1, srcB=0, reg_write=1; retired=1.
REQ-019 ir=16'hC200 (LD) with mem_ready low 3 cycles in MEMORY (macro defined) -> MEMORY held 4 cycles, mem_ren=1, reg_write=1 only on final cycle; macro undefined -> MEMORY 1 cycle.
REQ-020 ir=16'hE600 (BNE), cc=4'b0100 -> branch_taken=0, reg_write=0; cc=4'b0000 -> branch_taken=1, reg_write=1, dest=7.
REQ-021 halt_req=1 asserted during FETCH -> completes EXECUTE, enters HALT, retired frozen; halt_req=0 -> FETCH next cycle.
REQ-022 rst asserted in MEMORY wait -> next cycle state=00, ir=0, retired=0.
REQ-023 CNT_WIDTH=4, 16 ADD instructions -> retired wraps 15->0.
